// File: rtl/timer_bank_if.sv
// timer_bank_if: rd/wr/addr/wdata/rdata peripheral bus shared with data memory.
// master drives the strobes and address; slave returns combinational rdata.
interface timer_bank_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: NCH memory-mapped TH/TL/TCON timers with per-channel IRQ.
// Optional one-shot mode (TCON bit3) enabled by defining TIMER_ONESHOT_EN.
module timer_bank #(
  parameter int          NCH       = 2,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic           clk,
  input  logic           reset,
  timer_bank_if.slave    bus,
  output logic [NCH-1:0] irq_vec,
  output logic           irqout
);

  localparam logic [31:0] END_ADDR =
    BASE_ADDR + 32'(16 * NCH);
  localparam logic [DW-1:0] ONES = '1;

  logic [DW-1:0]  r_th [NCH];
  logic [DW-1:0]  r_tl [NCH];
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_ien;
  logic [NCH-1:0] r_stat;
  logic [NCH-1:0] w_os;

  logic        w_hit;
  logic [31:0] w_off;
  logic [2:0]  w_ch;
  logic [1:0]  w_reg;
  logic        w_unused;

  logic [NCH-1:0] w_wth;
  logic [NCH-1:0] w_wtl;
  logic [NCH-1:0] w_wtc;
  logic [NCH-1:0] w_ovf;
  logic [31:0]    w_rdata;

  assign w_hit = (bus.addr >= BASE_ADDR) &&
                 (bus.addr <  END_ADDR);
  assign w_off = bus.addr - BASE_ADDR;
  assign w_ch  = w_off[6:4];
  assign w_reg = w_off[3:2];

  assign w_unused = ^{w_off[31:7], w_off[1:0],
                      bus.wdata};

  always_comb begin
    w_wth = '0;
    w_wtl = '0;
    w_wtc = '0;
    w_ovf = '0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.wr && w_hit && w_ch == 3'(k)) begin
        w_wth[k] = (w_reg == 2'd0);
        w_wtl[k] = (w_reg == 2'd1);
        w_wtc[k] = (w_reg == 2'd2);
      end
      w_ovf[k] = r_en[k] && (r_tl[k] == ONES);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        r_th[k] <= '0;
        r_tl[k] <= '0;
      end
      r_en   <= '0;
      r_ien  <= '0;
      r_stat <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wth[k])
          r_th[k] <= bus.wdata[DW-1:0];

        // Reload uses the pre-write TH; a CPU TL write wins.
        if (w_wtl[k])
          r_tl[k] <= bus.wdata[DW-1:0];
        else if (w_ovf[k])
          r_tl[k] <= r_th[k];
        else if (r_en[k])
          r_tl[k] <= r_tl[k] + 1'b1;

        if (w_wtc[k])
          r_ien[k] <= bus.wdata[1];

        // Overflow set beats a same-cycle W1C.
        if (w_ovf[k] && r_ien[k])
          r_stat[k] <= 1'b1;
        else if (w_wtc[k] && bus.wdata[2])
          r_stat[k] <= 1'b0;

`ifdef TIMER_ONESHOT_EN
        if (w_wtc[k])
          r_en[k] <= bus.wdata[0];
        else if (w_ovf[k] && w_os[k])
          r_en[k] <= 1'b0;
`else
        if (w_wtc[k])
          r_en[k] <= bus.wdata[0];
`endif
      end
    end
  end

`ifdef TIMER_ONESHOT_EN
  logic [NCH-1:0] r_os;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_os <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_wtc[k])
          r_os[k] <= bus.wdata[3];
      end
    end
  end

  assign w_os = r_os;
`else
  assign w_os = '0;
`endif

  always_comb begin
    w_rdata = '0;
    if (bus.rd && w_hit) begin
      for (int k = 0; k < NCH; k++) begin
        if (w_ch == 3'(k)) begin
          case (w_reg)
            2'd0: w_rdata[DW-1:0] = r_th[k];
            2'd1: w_rdata[DW-1:0] = r_tl[k];
            2'd2: w_rdata[3:0] =
                    {w_os[k], r_stat[k],
                     r_ien[k], r_en[k]};
            default: w_rdata = '0;
          endcase
        end
      end
    end
  end

  assign bus.rdata = w_rdata;
  assign irq_vec   = r_stat & r_ien;
  assign irqout    = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: vector table, corner-case sequences and a random run
// against a register-level reference model of the two-channel timer.
module tb_timer_bank;

  localparam logic [31:0] B = 32'h4000_0000;
`ifdef TIMER_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] irq_vec;
  logic       irqout;

  timer_bank_if bus();

  timer_bank #(
    .NCH(2),
    .DW(32),
    .BASE_ADDR(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .irq_vec(irq_vec),
    .irqout(irqout)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [1:0]  irq;
    string       name;
  } vec_t;

  vec_t tv[$];

  // reference model state
  logic [31:0] m_th [2];
  logic [31:0] m_tl [2];
  bit          m_en [2];
  bit          m_ien [2];
  bit          m_stat [2];
  bit          m_os [2];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic step(input bit r, input bit w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    bus.rd    = r;
    bus.wr    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(negedge clk);
    idle_in();
  endtask

  task automatic wr_reg(input logic [31:0] a,
                        input logic [31:0] d);
    step(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_reg(input string name,
                         input logic [31:0] a,
                         input logic [31:0] exp);
    logic [31:0] v;
    bus.rd   = 1'b1;
    bus.addr = a;
    #1;
    v = bus.rdata;
    bus.rd   = 1'b0;
    chk(name, v, exp);
  endtask

  task automatic add(input bit r, input bit w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [31:0] e,
                     input string n);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a;
    v.wdata = d; v.exp = e; v.irq = 2'b00;
    v.name = n;
    tv.push_back(v);
  endtask

  function automatic logic [31:0] m_read(
      input bit r, input logic [31:0] a);
    logic [31:0] off;
    int ch, rg;
    if (!r || a < B || a >= B + 32)
      return 32'h0;
    off = a - B;
    ch  = int'(off / 16);
    rg  = int'((off % 16) / 4);
    case (rg)
      0: return m_th[ch];
      1: return m_tl[ch];
      2: return {28'h0, OS & m_os[ch], m_stat[ch],
                 m_ien[ch], m_en[ch]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_th[c] = 0; m_tl[c] = 0; m_en[c] = 0;
      m_ien[c] = 0; m_stat[c] = 0; m_os[c] = 0;
    end
  endtask

  task automatic m_step(input bit w,
                        input logic [31:0] a,
                        input logic [31:0] d);
    int wch, wrg;
    bit ovf;
    logic [31:0] n_th, n_tl;
    bit n_en, n_ien, n_stat, n_os;
    wch = -1;
    wrg = 0;
    if (w && a >= B && a < B + 32) begin
      wch = int'((a - B) / 16);
      wrg = int'(((a - B) % 16) / 4);
    end
    for (int c = 0; c < 2; c++) begin
      ovf  = m_en[c] && (m_tl[c] == 32'hFFFF_FFFF);
      n_th = m_th[c];
      n_tl = ovf ? m_th[c]
           : (m_en[c] ? m_tl[c] + 1 : m_tl[c]);
      n_en = m_en[c]; n_ien = m_ien[c];
      n_stat = m_stat[c]; n_os = m_os[c];
      if (ovf && OS && m_os[c]) n_en = 0;
      if (wch == c) begin
        case (wrg)
          0: n_th = d;
          1: n_tl = d;
          2: begin
            n_en  = d[0];
            n_ien = d[1];
            if (OS) n_os = d[3];
            if (d[2]) n_stat = 0;
          end
          default: ;
        endcase
      end
      if (ovf && m_ien[c]) n_stat = 1;
      m_th[c] = n_th; m_tl[c] = n_tl;
      m_en[c] = n_en; m_ien[c] = n_ien;
      m_stat[c] = n_stat; m_os[c] = n_os;
    end
  endtask

  function automatic logic [31:0] rnd_data(input int rg);
    int s;
    s = int'($urandom_range(0, 3));
    if (rg == 2) return 32'($urandom_range(0, 15));
    case (s)
      0: return $urandom;
      1: return 32'($urandom_range(0, 8));
      default:
        return 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
    endcase
  endfunction

  initial begin
    logic [31:0] a, d, e;
    logic [1:0] ei;
    bit r, w;
    int ch, rg;

    idle_in();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      chk_reg("reset_reg", B + 32'(4 * i), 32'h0);
      @(negedge clk);
    end
    chk("reset_irqout", 32'(irqout), 32'h0);
    chk("reset_irqvec", 32'(irq_vec), 32'h0);

    add(0, 1, B + 32'h00, 32'h1234_5678, 0, "wr_th0");
    add(1, 0, B + 32'h00, 0, 32'h1234_5678, "rd_th0");
    add(0, 1, B + 32'h14, 32'hAB, 0, "wr_tl1");
    add(1, 0, B + 32'h14, 0, 32'hAB, "rd_tl1");
    add(1, 0, B + 32'h2C, 0, 0, "rd_miss_2c");
    add(1, 0, B + 32'h20, 0, 0, "rd_miss_20");
    add(0, 1, B + 32'h20, 32'hFFFF, 0, "wr_miss");
    add(1, 0, B + 32'h10, 0, 0, "rd_th1_after_miss");
    add(0, 1, B + 32'h0C, 32'h5, 0, "wr_pad");
    add(1, 0, B + 32'h0C, 0, 0, "rd_pad");
    add(1, 0, B + 32'h03, 0, 32'h1234_5678, "rd_lowbits");
    add(1, 1, B + 32'h00, 32'h55, 32'h1234_5678,
        "rd_wr_same");
    add(1, 0, B + 32'h00, 0, 32'h55, "rd_th0_new");
    add(1, 0, B - 32'h4, 0, 0, "rd_below_base");
    add(0, 1, B + 32'h18, 32'h8, 0, "wr_tcon1_os");
    add(1, 0, B + 32'h18, 0, OS ? 32'h8 : 32'h0,
        "rd_tcon1_os");
    add(0, 1, B + 32'h18, 32'h0, 0, "wr_tcon1_clr");
    add(1, 0, B + 32'h08, 0, 0, "rd_tcon0");

    foreach (tv[i]) begin
      bus.rd    = tv[i].rd;
      bus.wr    = tv[i].wr;
      bus.addr  = tv[i].addr;
      bus.wdata = tv[i].wdata;
      #1;
      chk(tv[i].name, bus.rdata, tv[i].exp);
      chk({tv[i].name, "_irq"}, 32'(irq_vec),
          32'(tv[i].irq));
      @(negedge clk);
      idle_in();
    end

    // periodic IRQ, W1C, and overflow collisions on channel 0
    wr_reg(B + 32'h0, 32'hFFFF_FFFC);
    wr_reg(B + 32'h4, 32'hFFFF_FFFC);
    wr_reg(B + 32'h8, 32'h3);
    idle(4);
    chk_reg("per_tl_reload", B + 32'h4, 32'hFFFF_FFFC);
    chk_reg("per_tcon_stat", B + 32'h8, 32'h7);
    chk("per_irqout", 32'(irqout), 32'h1);
    wr_reg(B + 32'h8, 32'h7);
    chk_reg("w1c_tcon", B + 32'h8, 32'h3);
    chk("w1c_irqout", 32'(irqout), 32'h0);
    idle(2);
    chk_reg("pre_ovf_tl", B + 32'h4, 32'hFFFF_FFFF);
    chk("pre_ovf_irqout", 32'(irqout), 32'h0);
    wr_reg(B + 32'h8, 32'h7);
    chk_reg("w1c_vs_ovf_tcon", B + 32'h8, 32'h7);
    chk_reg("w1c_vs_ovf_tl", B + 32'h4, 32'hFFFF_FFFC);
    chk("w1c_vs_ovf_irq", 32'(irqout), 32'h1);
    idle(3);
    wr_reg(B + 32'h0, 32'h100);
    chk_reg("th_vs_ovf_tl", B + 32'h4, 32'hFFFF_FFFC);
    chk_reg("th_vs_ovf_th", B + 32'h0, 32'h100);
    wr_reg(B + 32'h4, 32'h10);
    chk_reg("tl_vs_inc", B + 32'h4, 32'h10);
    idle(1);
    chk_reg("tl_inc_after", B + 32'h4, 32'h11);
    wr_reg(B + 32'h8, 32'h4);
    chk_reg("stop_tcon", B + 32'h8, 32'h0);
    chk("stop_irqout", 32'(irqout), 32'h0);

    // disable in the overflow cycle: reload and stat still happen
    wr_reg(B + 32'h4, 32'hFFFF_FFFF);
    wr_reg(B + 32'h8, 32'h3);
    wr_reg(B + 32'h8, 32'h2);
    chk_reg("dis_ovf_tl", B + 32'h4, 32'h100);
    chk_reg("dis_ovf_tcon", B + 32'h8, 32'h6);
    idle(1);
    chk_reg("dis_ovf_hold", B + 32'h4, 32'h100);
    wr_reg(B + 32'h8, 32'h4);

    // channel isolation
    wr_reg(B + 32'h04, 32'h50);
    wr_reg(B + 32'h10, 32'hFFFF_FFFE);
    wr_reg(B + 32'h14, 32'hFFFF_FFFE);
    wr_reg(B + 32'h18, 32'h3);
    idle(2);
    chk("iso_irqvec", 32'(irq_vec), 32'h2);
    chk_reg("iso_tl0", B + 32'h04, 32'h50);
    chk_reg("iso_tl1", B + 32'h14, 32'hFFFF_FFFE);
    wr_reg(B + 32'h18, 32'h4);
    chk("iso_irq_clr", 32'(irq_vec), 32'h0);

    // one-shot bit (or its absence)
    wr_reg(B + 32'h0, 32'hFFFF_FFFE);
    wr_reg(B + 32'h4, 32'hFFFF_FFFE);
    wr_reg(B + 32'h8, 32'hB);
    chk_reg("os_tcon_wr", B + 32'h8, OS ? 32'hB : 32'h3);
    idle(2);
    chk_reg("os_tl_ovf", B + 32'h4, 32'hFFFF_FFFE);
    chk_reg("os_tcon_ovf", B + 32'h8, OS ? 32'hE : 32'h7);
    idle(1);
    chk_reg("os_tl_after", B + 32'h4,
            OS ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    wr_reg(B + 32'h8, 32'h4);

    // reset in the middle of counting
    wr_reg(B + 32'h4, 32'h100);
    wr_reg(B + 32'h8, 32'h1);
    idle(2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    chk_reg("rst_mid_tl", B + 32'h4, 32'h0);
    chk_reg("rst_mid_tcon", B + 32'h8, 32'h0);
    chk("rst_mid_irqout", 32'(irqout), 32'h0);
    idle(2);
    chk_reg("rst_mid_hold", B + 32'h4, 32'h0);
    chk_reg("rst_mid_th", B + 32'h0, 32'h0);

    // random traffic against the reference model
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      ch = int'($urandom_range(0, 2));
      rg = int'($urandom_range(0, 3));
      a  = B + 32'(16 * ch + 4 * rg) +
           32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      d = rnd_data(rg);
      r = bit'($urandom_range(0, 1));
      w = ($urandom_range(0, 3) == 0);
      bus.rd = r; bus.wr = w;
      bus.addr = a; bus.wdata = d;
      #1;
      e  = m_read(r, a);
      ei = {m_stat[1] & m_ien[1], m_stat[0] & m_ien[0]};
      chk("rnd_rdata", bus.rdata, e);
      chk("rnd_irqvec", 32'(irq_vec), 32'(ei));
      chk("rnd_irqout", 32'(irqout), 32'(|ei));
      m_step(w, a, d);
      @(negedge clk);
      idle_in();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
